cal_sig_gen: RTL

Programmable periodic calibration-signal generator for the measure unit: the transmitting end of the `sig_i` / `run_det_i` pair consumed by the strobe generator. It produces a rectangular pulse train with a software-set period and high time, and holds a run-detect level so the downstream strobe generator can lock onto the train. New settings are double-buffered and applied only on a period boundary, so `sig_o` never glitches.

---
 rtl/cal_sig_gen.sv | 115 +++++++++++
 1 files changed

// File: rtl/cal_sig_gen.sv
// rtl/cal_sig_gen.sv - programmable periodic calibration pulse generator with double-buffered config
module cal_sig_gen #(
    parameter int CNT_WIDTH  = 32,
    parameter int MIN_PERIOD = 4
) (
    input  logic                 clk_i,
    input  logic                 arstn_i,
    input  logic [CNT_WIDTH-1:0] period_i,
    input  logic [CNT_WIDTH-1:0] high_i,
    input  logic                 load_i,
    input  logic                 start_i,
    input  logic                 stop_i,
    output logic                 sig_o,
    output logic                 run_det_o,
    output logic                 busy_o,
    output logic                 err_o,
    output logic [CNT_WIDTH-1:0] edge_cnt_o
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [CNT_WIDTH-1:0] ONE   = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] MIN_P = CNT_WIDTH'(MIN_PERIOD);

    state_t               state;
    logic [CNT_WIDTH-1:0] act_period;
    logic [CNT_WIDTH-1:0] act_high;
    logic                 act_valid;
    logic [CNT_WIDTH-1:0] sh_period;
    logic [CNT_WIDTH-1:0] sh_high;
    logic                 pend;
    logic [CNT_WIDTH-1:0] ph;

    logic                 load_ok;
    logic                 wrap;
    logic [CNT_WIDTH-1:0] ph_next;
    logic [CNT_WIDTH-1:0] nxt_high;

    always_comb begin
        load_ok  = (period_i >= MIN_P) && (high_i != '0) && (high_i < period_i);
        wrap     = (ph == act_period - ONE);
        ph_next  = wrap ? '0 : ph + ONE;
        // the shadow high time governs the period that begins right after a wrap
        nxt_high = (wrap && pend) ? sh_high : act_high;
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state      <= IDLE;
            act_period <= '0;
            act_high   <= '0;
            act_valid  <= 1'b0;
            sh_period  <= '0;
            sh_high    <= '0;
            pend       <= 1'b0;
            ph         <= '0;
            sig_o      <= 1'b0;
            run_det_o  <= 1'b0;
            busy_o     <= 1'b0;
            err_o      <= 1'b0;
            edge_cnt_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i && act_valid && !stop_i) begin
                        state      <= RUN;
                        ph         <= '0;
                        sig_o      <= 1'b1;
                        edge_cnt_o <= ONE;
                        run_det_o  <= 1'b1;
                        busy_o     <= 1'b1;
                    end
                end
                RUN, DRAIN: begin
                    ph <= ph_next;
                    if (wrap && pend) begin
                        act_period <= sh_period;
                        act_high   <= sh_high;
                        pend       <= 1'b0;
                    end
                    if (state == DRAIN && wrap) begin
                        state     <= IDLE;
                        sig_o     <= 1'b0;
                        run_det_o <= 1'b0;
                        busy_o    <= 1'b0;
                    end else begin
                        sig_o <= (ph_next < nxt_high);
                        if (wrap) edge_cnt_o <= edge_cnt_o + ONE;
                        if (state == RUN && stop_i) state <= DRAIN;
                    end
                end
                default: state <= IDLE;
            endcase

            // a load coinciding with a wrap lands in the shadow after the wrap has consumed it
            if (load_i) begin
                if (!load_ok) begin
                    err_o <= 1'b1;
                end else begin
                    err_o <= 1'b0;
                    if (state == IDLE) begin
                        act_period <= period_i;
                        act_high   <= high_i;
                        act_valid  <= 1'b1;
                    end else begin
                        sh_period <= period_i;
                        sh_high   <= high_i;
                        pend      <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
